// File: rtl/adc_captura_pmod.sv
// AD7476 capture front end: periodic conversion trigger, SPI-style read of one
// 16-bit frame, and conversion of the 12-bit offset-binary code to signed fixed point.
module adc_captura_pmod #(
    parameter int N       = 24,
    parameter int F       = 12,
    parameter int DIV     = 4,
    parameter int PERIODO = 2000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         habilitar,
    input  logic         sdata,
    output logic         cs,
    output logic         sclk,
    output logic [N-1:0] uk,
    output logic         datolisto,
    output logic [11:0]  dato_crudo,
    output logic         sobrecarga,
    output logic [1:0]   o_estado
);

    localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int DW = $clog2(DIV);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        CONV   = 2'd1,
        LISTO  = 2'd2
    } estado_t;

    estado_t       r_estado;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_div;
    logic [4:0]    r_tog;
    logic [15:0]   r_shift;
    logic          r_cs;
    logic          r_sclk;
    logic          r_datolisto;
    logic          r_sobre;
    logic [N-1:0]  r_uk;
    logic [11:0]   r_dato;

    logic          w_tick;
    logic          w_fin_half;
    logic [15:0]   w_word;
    logic [11:0]   w_val;
    logic [N-1:0]  w_uk;
    logic          w_unused_msb;

    always_comb begin
        w_tick       = habilitar && (r_cnt == CW'(PERIODO - 1));
        w_fin_half   = (r_div == DW'(DIV - 1));
        w_word       = {r_shift[14:0], sdata};
        // Offset binary to two's complement is an MSB inversion.
        w_val        = {~w_word[11], w_word[10:0]};
        w_uk         = {{(N-12){w_val[11]}}, w_val} << (F - 11);
        w_unused_msb = r_shift[15];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!habilitar || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado    <= REPOSO;
            r_div       <= '0;
            r_tog       <= '0;
            r_shift     <= '0;
            r_cs        <= 1'b1;
            r_sclk      <= 1'b1;
            r_datolisto <= 1'b0;
            r_sobre     <= 1'b0;
            r_uk        <= '0;
            r_dato      <= '0;
        end else begin
            if (w_tick && r_estado != REPOSO) begin
                r_sobre <= 1'b1;
            end
            case (r_estado)
                REPOSO: begin
                    r_datolisto <= 1'b0;
                    if (w_tick) begin
                        r_estado <= CONV;
                        r_cs     <= 1'b0;
                        r_sclk   <= 1'b1;
                        r_div    <= '0;
                        r_tog    <= '0;
                    end
                end
                CONV: begin
                    if (w_fin_half) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        r_tog  <= r_tog + 5'd1;
                        // A low-to-high sclk transition is the ADC sampling point.
                        if (!r_sclk) begin
                            r_shift <= w_word;
                        end
                        if (r_tog == 5'd31) begin
                            r_estado    <= LISTO;
                            r_cs        <= 1'b1;
                            r_datolisto <= 1'b1;
                            r_uk        <= w_uk;
                            r_dato      <= w_word[11:0];
                        end
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                LISTO: begin
                    r_datolisto <= 1'b0;
                    r_estado    <= REPOSO;
                end
                default: begin
                    r_estado <= REPOSO;
                end
            endcase
        end
    end

    assign cs         = r_cs;
    assign sclk       = r_sclk;
    assign datolisto  = r_datolisto;
    assign sobrecarga = r_sobre;
    assign uk         = r_uk;
    assign dato_crudo = r_dato;
    assign o_estado   = r_estado;

endmodule
